// File: rtl/rx_deserializer.sv
// UART receive deserializer: shifts RXD on mid-bit strobes, checks parity/stop,
// and commits each frame to a single-entry holding register read via RXRDY/RD.
module rx_deserializer #(
    parameter int unsigned SIZE       = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic            SAMPLE,
    input  logic            RXD,
    input  logic            RD,
    output logic [SIZE-1:0] DOUT,
    output logic            RXRDY,
    output logic            PERR,
    output logic            FERR,
    output logic            OVR,
    output logic            BUSY
);

    localparam int unsigned CW = $clog2(SIZE) + 1;
    localparam int unsigned IW = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    state_e          state_q;
    logic [SIZE-1:0] shift_q;
    logic [CW-1:0]   bit_cnt_q;
    logic            perr_int_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            perr_int_q <= 1'b0;
            DOUT       <= '0;
            RXRDY      <= 1'b0;
            PERR       <= 1'b0;
            FERR       <= 1'b0;
            OVR        <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            if (RD && RXRDY) begin
                RXRDY <= 1'b0;
                OVR   <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (START) begin
                        state_q   <= StData;
                        bit_cnt_q <= '0;
                        shift_q   <= '0;
                        BUSY      <= 1'b1;
                    end
                end
                StData: begin
                    if (SAMPLE) begin
                        shift_q[bit_cnt_q[IW-1:0]] <= RXD;
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                        if (bit_cnt_q == CW'(SIZE - 1)) begin
                            state_q <= (PARITY_EN != 0) ? StParity : StStop;
                        end
                    end
                end
                StParity: begin
                    if (SAMPLE) begin
                        perr_int_q <= ((^shift_q) ^ RXD) != 1'(PARITY_ODD);
                        state_q    <= StStop;
                    end
                end
                StStop: begin
                    if (SAMPLE) begin
                        DOUT    <= shift_q;
                        FERR    <= ~RXD;
                        PERR    <= (PARITY_EN != 0) ? perr_int_q : 1'b0;
                        RXRDY   <= 1'b1;
                        // A simultaneous RD consumes the old word, so no overrun then.
                        if (RXRDY && !RD) begin
                            OVR <= 1'b1;
                        end
                        state_q <= StIdle;
                        BUSY    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_deserializer.sv
// Scoreboard bench for rx_deserializer: one plain instance and one with even parity.
module tb_rx_deserializer;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;

    logic       clk;
    logic       rst    [2];
    logic       start  [2];
    logic       sample [2];
    logic       rxd    [2];
    logic       rd     [2];
    logic [7:0] dout   [2];
    logic       rxrdy  [2];
    logic       perr   [2];
    logic       ferr   [2];
    logic       ovr    [2];
    logic       busy   [2];

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    logic       prev_rdy  [2];
    logic [7:0] prev_dout [2];

    rx_deserializer #(.SIZE(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .CLK(clk), .RST(rst[0]), .START(start[0]), .SAMPLE(sample[0]), .RXD(rxd[0]),
        .RD(rd[0]), .DOUT(dout[0]), .RXRDY(rxrdy[0]), .PERR(perr[0]), .FERR(ferr[0]),
        .OVR(ovr[0]), .BUSY(busy[0])
    );

    rx_deserializer #(.SIZE(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_par (
        .CLK(clk), .RST(rst[1]), .START(start[1]), .SAMPLE(sample[1]), .RXD(rxd[1]),
        .RD(rd[1]), .DOUT(dout[1]), .RXRDY(rxrdy[1]), .PERR(perr[1]), .FERR(ferr[1]),
        .OVR(ovr[1]), .BUSY(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a new word is presented when RXRDY rises or DOUT changes while RXRDY=1.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst[d] && rxrdy[d] && (!prev_rdy[d] || dout[d] != prev_dout[d])) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    check("unexpected_word", 32'(dout[d]), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    check("sb_dout", 32'(dout[d]), 32'(e.data));
                    check("sb_perr", 32'(perr[d]), 32'(e.perr));
                    check("sb_ferr", 32'(ferr[d]), 32'(e.ferr));
                    check("sb_ovr", 32'(ovr[d]), 32'(e.ovr));
                end
            end
            prev_rdy[d]  = rxrdy[d];
            prev_dout[d] = dout[d];
        end
    end

    task automatic send_frame(input int d, input logic [7:0] data, input logic par,
                              input logic stop, input bit rd_at_stop, input bit spurious,
                              input bit start_sample, input logic e_perr, input logic e_ferr,
                              input logic e_ovr);
        @(negedge clk);
        start[d] = 1'b1;
        if (start_sample) begin
            sample[d] = 1'b1;
            rxd[d]    = 1'b0;
        end
        @(negedge clk);
        start[d]  = 1'b0;
        sample[d] = 1'b0;
        check("busy_in_frame", 32'(busy[d]), 32'd1);
        for (int i = 0; i < 8; i++) begin
            sample[d] = 1'b1;
            rxd[d]    = data[i];
            @(negedge clk);
            sample[d] = 1'b0;
            if (spurious && i == 3) start[d] = 1'b1;
            @(negedge clk);
            start[d] = 1'b0;
        end
        if (d == 1) begin
            sample[d] = 1'b1;
            rxd[d]    = par;
            @(negedge clk);
            sample[d] = 1'b0;
            @(negedge clk);
        end
        if (d == 0) q0.push_back('{data, e_perr, e_ferr, e_ovr});
        else        q1.push_back('{data, e_perr, e_ferr, e_ovr});
        sample[d] = 1'b1;
        rxd[d]    = stop;
        rd[d]     = rd_at_stop;
        @(negedge clk);
        sample[d] = 1'b0;
        rd[d]     = 1'b0;
        rxd[d]    = 1'b1;
        check("rxrdy_latency", 32'(rxrdy[d]), 32'd1);
        check("busy_after_stop", 32'(busy[d]), 32'd0);
    endtask

    task automatic read_word(input int d, input logic [7:0] exp_data);
        @(negedge clk);
        rd[d] = 1'b1;
        @(negedge clk);
        rd[d] = 1'b0;
        check("rd_clears_rxrdy", 32'(rxrdy[d]), 32'd0);
        check("rd_clears_ovr", 32'(ovr[d]), 32'd0);
        check("dout_held_after_rd", 32'(dout[d]), 32'(exp_data));
    endtask

    task automatic check_all_zero(input int d);
        check("zero_dout", 32'(dout[d]), 32'd0);
        check("zero_rxrdy", 32'(rxrdy[d]), 32'd0);
        check("zero_perr", 32'(perr[d]), 32'd0);
        check("zero_ferr", 32'(ferr[d]), 32'd0);
        check("zero_ovr", 32'(ovr[d]), 32'd0);
        check("zero_busy", 32'(busy[d]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; start[d] = 1'b0; sample[d] = 1'b0; rxd[d] = 1'b1; rd[d] = 1'b0;
            prev_rdy[d] = 1'b0; prev_dout[d] = '0;
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        check_all_zero(0);
        check_all_zero(1);

        // Basic frame, then read.
        send_frame(0, 8'hA5, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        read_word(0, 8'hA5);

        // Framing error, then a good frame with a spurious START mid-frame.
        send_frame(0, 8'h5A, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        read_word(0, 8'h5A);
        send_frame(0, 8'h11, 1'b0, 1'b1, 0, 1, 0, 1'b0, 1'b0, 1'b0);

        // Overrun: 0x11 left unread.
        send_frame(0, 8'h22, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        read_word(0, 8'h22);

        // Commit coincident with RD: no overrun.
        send_frame(0, 8'h11, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h33, 1'b0, 1'b1, 1, 0, 0, 1'b0, 1'b0, 1'b0);

        // Reset mid-frame with 0x33 still unread.
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample[0] = 1'b1;
            rxd[0]    = 1'b0;
            @(negedge clk);
            sample[0] = 1'b0;
            @(negedge clk);
        end
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check_all_zero(0);
        for (int i = 0; i < 3; i++) begin
            sample[0] = 1'b1;
            rxd[0]    = 1'b1;
            @(negedge clk);
        end
        sample[0] = 1'b0;
        @(negedge clk);
        check("idle_sample_busy", 32'(busy[0]), 32'd0);
        check("idle_sample_rxrdy", 32'(rxrdy[0]), 32'd0);
        // START and SAMPLE together: the SAMPLE must not become a data bit.
        send_frame(0, 8'hC3, 1'b0, 1'b1, 0, 0, 1, 1'b0, 1'b0, 1'b0);

        // Even parity instance.
        send_frame(1, 8'h03, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        read_word(1, 8'h03);
        send_frame(1, 8'h03, 1'b1, 1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        read_word(1, 8'h03);
        send_frame(1, 8'h07, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_q0_drained", 32'(q0.size()), 32'd0);
        check("sb_q1_drained", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
